pwm_breath_ctrl: RTL and testbench

Breathing-LED sequencer for the board LED. It owns a free-running PWM period counter and ramps the duty cycle up, holds it, ramps it down and holds again, in a repeating cycle. The controller drives `led` through a registered compare stage, and only changes the duty value at period boundaries so no glitch pulses occur. It sits between the top-level `clk`/`rst_n` and the `led` pin, and replaces a fixed-duty PWM generator.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_gen.sv | 30 +++
 rtl/pwm_breath_ctrl.sv | 119 +++++++++++
 tb/tb_pwm_breath_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state encoding for the breathing-LED controller
package pwm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RAMP_UP = 3'd1;
    localparam logic [STATE_W-1:0] ST_HOLD_HI = 3'd2;
    localparam logic [STATE_W-1:0] ST_RAMP_DN = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD_LO = 3'd4;

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running period counter, period_end strobe and registered compare
module pwm_gen #(
    parameter int CNT_W  = 16,
    parameter int PERIOD = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] duty,
    output logic             period_end,
    output logic             led
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_led;

    assign period_end = (r_cnt == CNT_W'(PERIOD - 1));
    assign led        = r_led;

    // Counter wraps at the period boundary; led registers cnt < duty one clock later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else begin
            r_cnt <= period_end ? '0 : r_cnt + CNT_W'(1);
            r_led <= (r_cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl: breathing-LED sequencer ramping PWM duty up, holding, ramping down, holding
module pwm_breath_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int PERIOD       = 50000,
    parameter int STEP         = 500,
    parameter int HOLD_PERIODS = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               led,
    output logic [CNT_W-1:0]   duty,
    output logic [STATE_W-1:0] state,
    output logic               cycle_done
);

    localparam logic [CNT_W:0]   LP_PERIOD    = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   LP_STEP      = (CNT_W + 1)'(STEP);
    localparam logic [CNT_W-1:0] LP_DUTY_MAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LP_DUTY_STEP = CNT_W'(STEP);
    localparam logic [7:0]       LP_HOLD_LAST = 8'(HOLD_PERIODS - 1);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_duty;
    logic [7:0]         r_hold;

    logic               w_period_end;
    logic [CNT_W:0]     w_up_base;
    logic [CNT_W:0]     w_up_sum;
    logic [CNT_W-1:0]   w_up_duty;
    logic [CNT_W-1:0]   w_dn_duty;
    logic               w_hold_done;
    logic [STATE_W-1:0] w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_duty;
    logic [7:0]         w_nxt_hold;
    logic               w_done;

    pwm_gen #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty       (r_duty),
        .period_end (w_period_end),
        .led        (led)
    );

    // Ramps restart from 0 when entering RAMP_UP; the sum is one bit wider so it cannot wrap
    assign w_up_base   = (r_state == ST_RAMP_UP) ? {1'b0, r_duty} : '0;
    assign w_up_sum    = w_up_base + LP_STEP;
    assign w_up_duty   = (w_up_sum >= LP_PERIOD) ? LP_DUTY_MAX : w_up_sum[CNT_W-1:0];
    assign w_dn_duty   = (r_duty > LP_DUTY_STEP) ? r_duty - LP_DUTY_STEP : '0;
    assign w_hold_done = (r_hold == LP_HOLD_LAST);

    // Next state/duty/hold as evaluated at a period boundary; entering a ramp applies its first step
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_duty  = r_duty;
        w_nxt_hold  = '0;
        w_done      = 1'b0;
        if (!enable) begin
            w_nxt_state = ST_IDLE;
            w_nxt_duty  = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RAMP_UP: begin
                    w_nxt_duty  = w_up_duty;
                    w_nxt_state = (w_up_duty == LP_DUTY_MAX) ? ST_HOLD_HI : ST_RAMP_UP;
                end
                ST_HOLD_HI: begin
                    if (w_hold_done) begin
                        w_nxt_duty  = w_dn_duty;
                        w_nxt_state = (w_dn_duty == '0) ? ST_HOLD_LO : ST_RAMP_DN;
                    end else begin
                        w_nxt_hold = r_hold + 8'd1;
                    end
                end
                ST_RAMP_DN: begin
                    w_nxt_duty  = w_dn_duty;
                    w_nxt_state = (w_dn_duty == '0) ? ST_HOLD_LO : ST_RAMP_DN;
                end
                ST_HOLD_LO: begin
                    if (w_hold_done) begin
                        w_done      = 1'b1;
                        w_nxt_duty  = w_up_duty;
                        w_nxt_state = (w_up_duty == LP_DUTY_MAX) ? ST_HOLD_HI : ST_RAMP_UP;
                    end else begin
                        w_nxt_hold = r_hold + 8'd1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_duty  = '0;
                end
            endcase
        end
    end

    // FSM, duty and hold counter only advance on the last clock of a period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
            r_hold  <= '0;
        end else if (w_period_end) begin
            r_state <= w_nxt_state;
            r_duty  <= w_nxt_duty;
            r_hold  <= w_nxt_hold;
        end
    end

    assign duty       = r_duty;
    assign state      = r_state;
    assign cycle_done = w_period_end & w_done;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// tb_pwm_breath_ctrl: vector table, corner sequences and random enable against a breath-sequence model
module tb_pwm_breath_ctrl;

    localparam int P = 10;
    localparam int S = 3;
    localparam int H = 2;
    localparam int W = 16;
    localparam logic [2:0] IDLE = 3'd0, RU = 3'd1, HH = 3'd2, RD = 3'd3, HL = 3'd4;

    typedef struct {
        logic       en;
        logic       tog;
        int         duty;
        logic [2:0] st;
        int         high;
        int         done;
    } vec_t;

    logic         clk;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         led;
    logic         cycle_done;
    logic [W-1:0] duty;
    logic [2:0]   state;

    int         n_tests = 0;
    int         n_fail = 0;
    int         seq_d[64];
    logic [2:0] seq_s[64];
    int         seq_len = 0;
    int         m_cnt = 0;
    int         m_pos = -1;
    logic       m_led = 1'b0;
    vec_t       vecs[16];

    pwm_breath_ctrl #(
        .CNT_W        (W),
        .PERIOD       (P),
        .STEP         (S),
        .HOLD_PERIODS (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .led        (led),
        .duty       (duty),
        .state      (state),
        .cycle_done (cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_duty();
        return (m_pos < 0) ? 0 : seq_d[m_pos];
    endfunction

    function automatic int exp_state();
        return (m_pos < 0) ? 0 : int'(seq_s[m_pos]);
    endfunction

    function automatic void push(input int d, input logic [2:0] s);
        seq_d[seq_len] = d;
        seq_s[seq_len] = s;
        seq_len++;
    endfunction

    // Model: position within one precomputed breath cycle, -1 meaning idle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_pos <= -1;
            m_led <= 1'b0;
        end else begin
            m_led <= (m_cnt < exp_duty());
            m_cnt <= (m_cnt == P - 1) ? 0 : m_cnt + 1;
            if (m_cnt == P - 1)
                m_pos <= !enable ? -1 : ((m_pos == seq_len - 1) ? 0 : m_pos + 1);
        end
    end

    always @(negedge clk) begin
        chk("duty", int'(duty), exp_duty());
        chk("state", int'(state), exp_state());
        chk("led", int'(led), int'(m_led));
        chk("cycle_done", int'(cycle_done),
            (rst_n && m_cnt == P - 1 && enable && m_pos == seq_len - 1) ? 1 : 0);
    end

    // Starts inside a cnt=0 cycle; ends at the negedge of the next period's cnt=0 cycle
    task automatic run_period(input vec_t v, input int idx);
        int   high = 0;
        int   pulses = 0;
        logic seen0 = 1'b0;
        logic glitch = 1'b0;
        enable = v.en;
        chk($sformatf("v%0d duty", idx), int'(duty), v.duty);
        chk($sformatf("v%0d state", idx), int'(state), int'(v.st));
        for (int j = 0; j < P; j++) begin
            @(negedge clk);
            if (v.tog && j == 2) enable = 1'b0;
            if (v.tog && j == 4) enable = 1'b1;
            if (led) begin
                high++;
                if (seen0) glitch = 1'b1;
            end else begin
                seen0 = 1'b1;
            end
            pulses += int'(cycle_done);
        end
        chk($sformatf("v%0d led_high", idx), high, v.high);
        chk($sformatf("v%0d led_contiguous", idx), int'(glitch), 0);
        chk($sformatf("v%0d cycle_done_pulses", idx), pulses, v.done);
    endtask

    initial begin
        int d;
        d = 0;
        while (d < P) begin
            d = (d + S > P) ? P : d + S;
            if (d < P) push(d, RU);
        end
        repeat (H) push(P, HH);
        while (d > 0) begin
            d = (d > S) ? d - S : 0;
            if (d > 0) push(d, RD);
        end
        repeat (H) push(0, HL);

        vecs[0]  = '{1'b1, 1'b0, 0,  IDLE, 0,  0};
        vecs[1]  = '{1'b1, 1'b0, 3,  RU,   3,  0};
        vecs[2]  = '{1'b1, 1'b0, 6,  RU,   6,  0};
        vecs[3]  = '{1'b1, 1'b0, 9,  RU,   9,  0};
        vecs[4]  = '{1'b1, 1'b0, 10, HH,   10, 0};
        vecs[5]  = '{1'b1, 1'b0, 10, HH,   10, 0};
        vecs[6]  = '{1'b1, 1'b0, 7,  RD,   7,  0};
        vecs[7]  = '{1'b1, 1'b0, 4,  RD,   4,  0};
        vecs[8]  = '{1'b1, 1'b0, 1,  RD,   1,  0};
        vecs[9]  = '{1'b1, 1'b0, 0,  HL,   0,  0};
        vecs[10] = '{1'b1, 1'b0, 0,  HL,   0,  1};
        vecs[11] = '{1'b1, 1'b0, 3,  RU,   3,  0};
        vecs[12] = '{1'b0, 1'b0, 6,  RU,   6,  0};
        vecs[13] = '{1'b1, 1'b0, 0,  IDLE, 0,  0};
        vecs[14] = '{1'b1, 1'b0, 3,  RU,   3,  0};
        vecs[15] = '{1'b1, 1'b1, 6,  RU,   6,  0};

        enable = 1'b1;
        #100 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) run_period(vecs[i], i);

        repeat (4) @(negedge clk);
        chk("pre_reset duty", int'(duty), 9);
        chk("pre_reset led", int'(led), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset duty", int'(duty), 0);
        chk("async_reset state", int'(state), 0);
        chk("async_reset led", int'(led), 0);
        chk("async_reset cycle_done", int'(cycle_done), 0);
        @(negedge clk);
        #5 rst_n = 1'b1;

        repeat (900) begin
            @(negedge clk);
            #2;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
